// File: rtl/nasti_dma_pkg.sv
// Shared types and constants for the NASTI DMA mover.
package nasti_dma_pkg;

  localparam int unsigned BOUNDARY_4K = 4096;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT_ADDR,
    ST_DATA,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/nasti_dma_burst_calc.sv
// Burst length in beats: limited by remaining work, MAX_BURST and the 4 KiB page of either side.
module nasti_dma_burst_calc
  import nasti_dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned MAX_BURST  = 256
) (
  input  logic [ADDR_WIDTH-1:0] remaining,
  input  logic [11:0]           src_off,
  input  logic [11:0]           dest_off,
  output logic [8:0]            beats
);

  localparam int unsigned SZ = $clog2(DATA_WIDTH / 8);

  logic [12:0] src_room;
  logic [12:0] dest_room;
  logic [12:0] cap;
  logic [12:0] m;

  always_comb begin
    src_room  = (13'(BOUNDARY_4K) - {1'b0, src_off}) >> SZ;
    dest_room = (13'(BOUNDARY_4K) - {1'b0, dest_off}) >> SZ;
    cap       = (remaining > ADDR_WIDTH'(MAX_BURST)) ? 13'(MAX_BURST) : 13'(remaining);
    m         = cap;
    if (src_room < m)  m = src_room;
    if (dest_room < m) m = dest_room;
    beats     = m[8:0];
  end

endmodule

// File: rtl/nasti_dma_mover.sv
// Memory-to-memory copy engine: reads bursts on src, streams them straight out on dest.
module nasti_dma_mover
  import nasti_dma_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 64,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MAX_BURST       = 256,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ADDR_WIDTH-1:0]   src_addr,
  input  logic [ADDR_WIDTH-1:0]   dest_addr,
  input  logic [ADDR_WIDTH-1:0]   length,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_resp,
  output logic                    src_ar_valid,
  input  logic                    src_ar_ready,
  output logic [ADDR_WIDTH-1:0]   src_ar_addr,
  output logic [7:0]              src_ar_len,
  output logic [2:0]              src_ar_size,
  output logic [1:0]              src_ar_burst,
  output logic [3:0]              src_ar_id,
  output logic [3:0]              src_ar_cache,
  output logic [2:0]              src_ar_prot,
  output logic                    src_ar_lock,
  input  logic                    src_r_valid,
  output logic                    src_r_ready,
  input  logic [DATA_WIDTH-1:0]   src_r_data,
  input  logic                    src_r_last,
  input  logic [1:0]              src_r_resp,
  output logic                    dest_aw_valid,
  input  logic                    dest_aw_ready,
  output logic [ADDR_WIDTH-1:0]   dest_aw_addr,
  output logic [7:0]              dest_aw_len,
  output logic [2:0]              dest_aw_size,
  output logic [1:0]              dest_aw_burst,
  output logic [3:0]              dest_aw_id,
  output logic [3:0]              dest_aw_cache,
  output logic [2:0]              dest_aw_prot,
  output logic                    dest_aw_lock,
  output logic                    dest_w_valid,
  input  logic                    dest_w_ready,
  output logic [DATA_WIDTH-1:0]   dest_w_data,
  output logic [DATA_WIDTH/8-1:0] dest_w_strb,
  output logic                    dest_w_last,
  input  logic                    dest_b_valid,
  output logic                    dest_b_ready,
  input  logic [1:0]              dest_b_resp
);

  localparam int unsigned SZ = $clog2(DATA_WIDTH / 8);
  localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [ADDR_WIDTH-1:0] ALIGN = ~((ADDR_WIDTH'(1) << SZ) - ADDR_WIDTH'(1));

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   src_cur, dest_cur, remaining, remaining_after;
  logic [8:0]              cur_beats, calc_beats, beat_cnt;
  logic [OW-1:0]           outstanding;
  logic                    ar_hs, aw_hs, r_hs, w_hs, b_hs;
  logic                    last_beat, can_issue, issue, finish;

  nasti_dma_burst_calc #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST)
  ) u_burst_calc (
    .remaining (remaining),
    .src_off   (src_cur[11:0]),
    .dest_off  (dest_cur[11:0]),
    .beats     (calc_beats)
  );

  assign ar_hs           = src_ar_valid & src_ar_ready;
  assign aw_hs           = dest_aw_valid & dest_aw_ready;
  assign r_hs            = src_r_valid & src_r_ready;
  assign w_hs            = dest_w_valid & dest_w_ready;
  assign b_hs            = dest_b_valid & dest_b_ready;
  assign last_beat       = (beat_cnt == cur_beats - 9'd1);
  assign remaining_after = remaining - ADDR_WIDTH'(cur_beats);
  assign can_issue       = (outstanding < OW'(MAX_OUTSTANDING));
  // Issue is gated here, so after a burst with work left the engine parks in ADDR until a B frees a slot.
  assign issue           = (state == ST_ADDR) && (remaining != '0) && can_issue;
  assign finish          = (state == ST_DRAIN) && (outstanding == '0);

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:      if (start) state_nx = ST_ADDR;
      ST_ADDR:      if (remaining == '0) state_nx = ST_DRAIN;
                    else if (can_issue) state_nx = ST_WAIT_ADDR;
      ST_WAIT_ADDR: if ((!src_ar_valid || src_ar_ready) && (!dest_aw_valid || dest_aw_ready))
                      state_nx = ST_DATA;
      ST_DATA:      if (w_hs && last_beat)
                      state_nx = (remaining_after == '0) ? ST_DRAIN : ST_ADDR;
      ST_DRAIN:     if (outstanding == '0) state_nx = ST_IDLE;
      default:      state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    src_r_ready  = 1'b0;
    dest_w_valid = 1'b0;
    dest_w_last  = 1'b0;
    if (state == ST_DATA) begin
      src_r_ready  = dest_w_ready;
      dest_w_valid = src_r_valid;
      dest_w_last  = last_beat;
    end
  end

  assign dest_b_ready  = (outstanding != '0);
  assign dest_w_data   = src_r_data;
  assign dest_w_strb   = '1;
  assign src_ar_addr   = src_cur;
  assign src_ar_len    = 8'(cur_beats - 9'd1);
  assign src_ar_size   = 3'(SZ);
  assign src_ar_burst  = BURST_INCR;
  assign src_ar_id     = '0;
  assign src_ar_cache  = '0;
  assign src_ar_prot   = '0;
  assign src_ar_lock   = 1'b0;
  assign dest_aw_addr  = dest_cur;
  assign dest_aw_len   = 8'(cur_beats - 9'd1);
  assign dest_aw_size  = 3'(SZ);
  assign dest_aw_burst = BURST_INCR;
  assign dest_aw_id    = '0;
  assign dest_aw_cache = '0;
  assign dest_aw_prot  = '0;
  assign dest_aw_lock  = 1'b0;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      src_cur       <= '0;
      dest_cur      <= '0;
      remaining     <= '0;
      cur_beats     <= '0;
      beat_cnt      <= '0;
      src_ar_valid  <= 1'b0;
      dest_aw_valid <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      if (state == ST_IDLE && start) begin
        src_cur   <= src_addr & ALIGN;
        dest_cur  <= dest_addr & ALIGN;
        remaining <= length >> SZ;
        busy      <= 1'b1;
      end
      if (issue) begin
        cur_beats     <= calc_beats;
        beat_cnt      <= '0;
        src_ar_valid  <= 1'b1;
        dest_aw_valid <= 1'b1;
      end else begin
        if (ar_hs) src_ar_valid  <= 1'b0;
        if (aw_hs) dest_aw_valid <= 1'b0;
      end
      if (w_hs) begin
        if (last_beat) begin
          beat_cnt  <= '0;
          src_cur   <= src_cur + (ADDR_WIDTH'(cur_beats) << SZ);
          dest_cur  <= dest_cur + (ADDR_WIDTH'(cur_beats) << SZ);
          remaining <= remaining_after;
        end else begin
          beat_cnt  <= beat_cnt + 9'd1;
        end
      end
      done <= finish;
      if (finish) busy <= 1'b0;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      outstanding <= '0;
    end else begin
      unique case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + OW'(1);
        2'b01:   outstanding <= outstanding - OW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      error    <= 1'b0;
      err_resp <= RESP_OKAY;
    end else if (state == ST_IDLE && start) begin
      error    <= 1'b0;
      err_resp <= RESP_OKAY;
    end else begin
      if (r_hs && (src_r_last != last_beat)) error <= 1'b1;
      // R wins the capture when both channels report a fault in the same cycle.
      if (r_hs && src_r_resp != RESP_OKAY) begin
        error <= 1'b1;
        if (!error) err_resp <= src_r_resp;
      end else if (b_hs && dest_b_resp != RESP_OKAY) begin
        error <= 1'b1;
        if (!error) err_resp <= dest_b_resp;
      end
    end
  end

endmodule

// File: doc/nasti_dma_mover.md
NASTI_DMA_MOVER -- requirements
Module: nasti_dma_mover

Interface
REQ-001 Parameter ADDR_WIDTH, 64, address and length width in bits.
REQ-002 Parameter DATA_WIDTH, 64, bus data width; power of two, 32..512.
REQ-003 Parameter MAX_BURST, 256, maximum beats per burst; 1..256.
REQ-004 Parameter MAX_OUTSTANDING, 4, maximum write bursts awaiting a B response; 1..15.
REQ-005 Port aclk  input  1  sole clock; all logic on its rising edge.
REQ-006 Port areset  input  1  reset, asynchronous, active-high.
REQ-007 Port src  nasti_channel.master  -  read side; only AR and R are used, all AW/W/B outputs tied 0.
REQ-008 Port dest  nasti_channel.master  -  write side; only AW, W and B are used, all AR/R outputs tied 0.
REQ-009 Ports src_addr, dest_addr, length  input  ADDR_WIDTH  byte addresses and byte count, sampled on start.
REQ-010 Port start  input  1  single-cycle request; ignored while busy=1.
REQ-011 Port busy  output  1  high from the cycle after an accepted start until completion.
REQ-012 Port done  output  1  one-cycle pulse on completion.
REQ-013 Port error  output  1  sticky: a non-OKAY response or an R-last mismatch occurred during the current transfer.
REQ-014 Port err_resp  output  2  first non-OKAY r_resp/b_resp code; 0 if none.

Function
REQ-015 The block SHALL drive ar_size/aw_size = log2(DATA_WIDTH/8), burst INCR, id 0, cache/prot/lock 0, all w_strb bits set.
REQ-016 Low log2(DATA_WIDTH/8) bits of src_addr, dest_addr and length SHALL be ignored; total beats = length >> log2(DATA_WIDTH/8).
REQ-017 A start with zero beats SHALL produce no bus traffic and SHALL pulse done exactly 2 cycles after start.
REQ-018 States: IDLE, ADDR, WAIT_ADDR, DATA, DRAIN; reset enters IDLE.
REQ-019 IDLE->ADDR on start: latch inputs, clear error/err_resp, set busy.
REQ-020 ADDR: burst beats = min(remaining, MAX_BURST, beats to next 4 KiB boundary of src, beats to next 4 KiB boundary of dest); assert ar_valid and aw_valid with len = beats-1; go to WAIT_ADDR.
REQ-021 WAIT_ADDR: each valid drops independently on its own handshake; go to DATA once both have handshaken, including same-cycle handshakes.
REQ-022 DATA: w_valid = r_valid, r_ready = w_ready, w_data = r_data; a beat counter drives w_last on the final beat of the burst.
REQ-023 r_last disagreeing with internal w_last SHALL set error; the data beat still passes.
REQ-024 On the final w handshake, addresses advance by beats*DATA_WIDTH/8 and remaining decrements; go to ADDR if remaining>0 and outstanding<MAX_OUTSTANDING; if remaining>0 otherwise, hold until a B response arrives; if remaining=0, go to DRAIN.
REQ-025 The outstanding counter SHALL increment on each AW handshake and decrement on each B handshake; both in one cycle SHALL leave it unchanged.
REQ-026 b_ready SHALL be 1 whenever outstanding>0.
REQ-027 DRAIN: when outstanding reaches 0, the block SHALL pulse done, clear busy and return to IDLE in the same edge.
REQ-028 A non-OKAY r_resp or b_resp SHALL set error and capture err_resp only if error was 0; the transfer SHALL continue to completion.

Reset
REQ-029 While areset=1: state IDLE; busy, done, error, err_resp, ar_valid, aw_valid, b_ready, the outstanding counter and the beat counter all 0.
REQ-030 Reset asserted mid-transfer SHALL drop all valids immediately; the resulting protocol abort on the bus is accepted.

Structure
REQ-031 Package nasti_dma_pkg SHALL hold the state enum, the BOUNDARY_4K = 4096 constant and the AXI response codes (OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3).
REQ-032 Sub-module nasti_dma_burst_calc SHALL be purely combinational, computing the burst beat count of REQ-020 from remaining, src and dest addresses.

Verification
REQ-033 Setup 64-bit bus, src 0x1000, dest 0x8000, length 0x800 -> one burst, len=255; 256 beats copied; done pulses once.
REQ-034 Setup src 0x0FF0, dest 0x2000, length 0x40 -> bursts of 2 beats and 6 beats; no burst crosses 0x1000.
REQ-035 Setup length 0x4000, MAX_OUTSTANDING=2, B delayed 50 cycles -> outstanding never exceeds 2; issue stalls until a B arrives.
REQ-036 Stimulus: b_resp=SLVERR on the 2nd burst and DECERR on the 3rd -> error=1, err_resp=2, transfer completes, done pulses.
REQ-037 Stimulus: areset asserted during DATA, then a fresh start -> all outputs 0 during reset; the new transfer completes correctly.
REQ-038 Stimulus: length=0x4 on a 64-bit bus, and start while busy -> no AR/AW issued; done pulses 2 cycles after start; the second start is ignored.
